carry_chain_pipe: RTL and testbench



---
 rtl/carry_chain_pipe.sv | 150 +++++++++++++++
 tb/tb_carry_chain_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/carry_chain_pipe.sv
// carry_chain_pipe: pipelined generate/propagate carry-chain evaluator.
// Evaluates c[i+1] = g[i] | (p[i] & c[i]) over N positions, SEG positions
// per register stage. A valid/ready handshake provides back-pressure, and a
// chained mode feeds the carry-out of one word into the next word.
module carry_chain_pipe #(
    parameter int N   = 8,
    parameter int SEG = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] g,
    input  logic [N-1:0] p,
    input  logic         carry_in,
    input  logic         chain_mode,
    input  logic         in_first,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] carries,
    output logic         carry_out
);

    localparam int L  = (N + SEG - 1) / SEG;
    localparam int OW = $clog2(L + 1) + 1;
    localparam logic [OW-1:0] OCC_ONE  = OW'(1);
    localparam logic [OW-1:0] OCC_ZERO = OW'(0);

    logic          advance_s;
    logic          in_xfer_s;
    logic          out_xfer_s;
    logic          c0_s;
    logic [OW-1:0] occ_r;
    logic          saved_carry_r;

    // The pipeline moves as a whole unless the output is valid and blocked.
    always_comb begin
        advance_s  = !out_valid || out_ready;
        out_xfer_s = out_valid && out_ready;
        if (chain_mode) begin
            in_ready = advance_s && (occ_r == OCC_ZERO);
        end else begin
            in_ready = advance_s;
        end
        in_xfer_s = in_valid && in_ready;
    end

    // Chain carry-in: a continuation word takes the saved carry.
    always_comb begin
        if (chain_mode && !in_first) begin
            c0_s = saved_carry_r;
        end else begin
            c0_s = carry_in;
        end
    end

    for (genvar k = 0; k < L; k++) begin : g_stage
        logic [N-1:0] src_g_s;
        logic [N-1:0] src_p_s;
        logic [N-1:0] src_car_s;
        logic         src_c_s;
        logic         src_vld_s;
        logic         src_chn_s;
        logic [N-1:0] car_nxt_s;
        logic         cseg_nxt_s;

        logic         vld_r;
        logic         chn_r;
        logic         cseg_r;
        logic [N-1:0] car_r;
        logic [N-1:0] g_r;
        logic [N-1:0] p_r;

        if (k == 0) begin : g_src_in
            assign src_g_s   = g;
            assign src_p_s   = p;
            assign src_car_s = '0;
            assign src_c_s   = c0_s;
            assign src_vld_s = in_xfer_s;
            assign src_chn_s = chain_mode;
        end else begin : g_src_prev
            assign src_g_s   = g_stage[k-1].g_r;
            assign src_p_s   = g_stage[k-1].p_r;
            assign src_car_s = g_stage[k-1].car_r;
            assign src_c_s   = g_stage[k-1].cseg_r;
            assign src_vld_s = g_stage[k-1].vld_r;
            assign src_chn_s = g_stage[k-1].chn_r;
        end

        // Ripple this stage's segment; earlier carries pass through untouched.
        always_comb begin
            logic c_v;
            c_v       = src_c_s;
            car_nxt_s = src_car_s;
            for (int i = 0; i < N; i++) begin
                if ((i >= k * SEG) && (i < (k + 1) * SEG)) begin
                    c_v          = src_g_s[i] | (src_p_s[i] & c_v);
                    car_nxt_s[i] = c_v;
                end else begin
                    car_nxt_s[i] = src_car_s[i];
                end
            end
            cseg_nxt_s = c_v;
        end

        // Stage register: loads on advance, otherwise holds (stall).
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_r  <= 1'b0;
                chn_r  <= 1'b0;
                cseg_r <= 1'b0;
                car_r  <= '0;
                g_r    <= '0;
                p_r    <= '0;
            end else if (advance_s) begin
                vld_r  <= src_vld_s;
                chn_r  <= src_chn_s;
                cseg_r <= cseg_nxt_s;
                car_r  <= car_nxt_s;
                g_r    <= src_g_s;
                p_r    <= src_p_s;
            end
        end
    end

    assign out_valid = g_stage[L-1].vld_r;
    assign carries   = g_stage[L-1].car_r;
    assign carry_out = g_stage[L-1].car_r[N-1];

    // Occupancy: words accepted but not yet handed downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_r <= OCC_ZERO;
        end else if (in_xfer_s && !out_xfer_s) begin
            occ_r <= occ_r + OCC_ONE;
        end else if (out_xfer_s && !in_xfer_s) begin
            occ_r <= occ_r - OCC_ONE;
        end
    end

    // Saved carry follows only chain-mode words as they leave.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            saved_carry_r <= 1'b0;
        end else if (out_xfer_s && g_stage[L-1].chn_r) begin
            saved_carry_r <= carry_out;
        end
    end

endmodule

// File: tb/tb_carry_chain_pipe.sv
// Directed bench for carry_chain_pipe with a queue-based scoreboard.
module tb_carry_chain_pipe;

    localparam int N   = 8;
    localparam int SEG = 3;
    localparam int L   = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic         carry_in;
    logic         chain_mode;
    logic         in_first;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] carries;
    logic         carry_out;

    int           vectors     = 0;
    int           miscompares = 0;
    logic [N:0]   exp_q[$];
    logic         model_saved = 1'b0;

    carry_chain_pipe #(.N(N), .SEG(SEG)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .g(g), .p(p), .carry_in(carry_in), .chain_mode(chain_mode),
        .in_first(in_first), .out_valid(out_valid), .out_ready(out_ready),
        .carries(carries), .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    function automatic logic [N:0] model(input logic [N-1:0] gv, input logic [N-1:0] pv,
                                         input logic c0);
        logic [N-1:0] r;
        logic         c;
        c = c0;
        for (int i = 0; i < N; i++) begin
            c    = gv[i] | (pv[i] & c);
            r[i] = c;
        end
        return {c, r};
    endfunction

    task automatic check(input string tag, input logic [N:0] obs, input logic [N:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [N-1:0] gv, input logic [N-1:0] pv, input logic cin,
                        input logic cm, input logic first);
        logic [N:0] e;
        logic       ok;
        ok = 1'b0;
        e  = model(gv, pv, (cm && !first) ? model_saved : cin);
        g = gv; p = pv; carry_in = cin; chain_mode = cm; in_first = first;
        in_valid = 1'b1;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (in_ready) begin
                exp_q.push_back(e);
                if (cm) model_saved = e[N];
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $error("FAIL send_timeout observed=no_accept expected=accept");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain", (N+1)'(exp_q.size()), (N+1)'(0));
    endtask

    // Scoreboard: compare each output transfer against the queued expectation.
    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL unexpected_out observed=%h expected=none", {carry_out, carries});
            end else if (out_ready) begin
                check("result", {carry_out, carries}, exp_q.pop_front());
            end else begin
                check("stall_hold", {carry_out, carries}, exp_q[0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst_n = 1'b0; in_valid = 1'b0; g = '0; p = '0; carry_in = 1'b0;
        chain_mode = 1'b0; in_first = 1'b0; out_ready = 1'b1;

        // Reset and idle.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", (N+1)'(out_valid), (N+1)'(0));
        check("rst_carries",   (N+1)'(carries),   (N+1)'(0));
        check("rst_carry_out", (N+1)'(carry_out), (N+1)'(0));
        check("rst_in_ready",  (N+1)'(in_ready),  (N+1)'(1));

        // Full propagate, including latency from the accepting edge.
        send(8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", (N+1)'(n), (N+1)'(L - 1));
        check("full_prop_1", {carry_out, carries}, {1'b1, 8'hFF});
        drain();
        send(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
        drain();

        // Kill / generate mix.
        send(8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
        send(8'h10, 8'hE0, 1'b0, 1'b0, 1'b0);
        drain();

        // Streaming with back-pressure.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(N'($urandom), N'($urandom), 1'($urandom), 1'b0, 1'b0);
        #1;
        check("full_in_ready_0", (N+1)'(in_ready), (N+1)'(0));
        @(negedge clk);
        #1;
        check("full_in_ready_1", (N+1)'(in_ready), (N+1)'(0));
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(N'($urandom), N'($urandom), 1'($urandom), 1'b0, 1'b0);
        drain();

        // Chained words: B waits for A to leave, then uses A's carry-out.
        send(8'h80, 8'h00, 1'b0, 1'b1, 1'b1);
        g = 8'h00; p = 8'hFF; chain_mode = 1'b1; in_first = 1'b0; in_valid = 1'b1;
        #1;
        check("chain_block", (N+1)'(in_ready), (N+1)'(0));
        @(negedge clk);
        send(8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);
        drain();
        // A normal word ignores the saved carry.
        send(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
        drain();

        // Reset mid-flight.
        out_ready = 1'b0;
        send(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        send(8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("pre_rst_valid", (N+1)'(out_valid), (N+1)'(1));
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", (N+1)'(out_valid), (N+1)'(0));
        check("async_rst_out", {carry_out, carries}, (N+1)'(0));
        exp_q.delete();
        model_saved = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h00, 8'hFF, 1'b1, 1'b1, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
